// File: rtl/jt1943_dwnld.sv
// Download writer: turns ioctl bytes into SDRAM byte writes (held until ack)
// or one-cycle PROM strobes, with a one-entry skid buffer for back-to-back bytes.
module jt1943_dwnld #(
    parameter logic [21:0] PROM_START = 22'h5_0000,
    parameter int          PROM_NUM   = 13
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic [21:0]         ioctl_addr,
    input  logic [7:0]          ioctl_data,
    input  logic                ioctl_wr,
    input  logic                sdram_ack,
    output logic [21:0]         prog_addr,
    output logic [7:0]          prog_data,
    output logic [1:0]          prog_mask,
    output logic                prog_we,
    output logic [PROM_NUM-1:0] prom_we,
    output logic                busy,
    output logic                overflow,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, SDWR, PROMWR} state_t;

    localparam logic [21:0]         PROM_SIZE = 22'(PROM_NUM * 256);
    localparam logic [PROM_NUM-1:0] PROM_ONE  = PROM_NUM'(1);

    state_t      state, state_nx;
    logic        cap;
    logic        buf_valid;
    logic [21:0] buf_addr;
    logic [7:0]  buf_data;
    logic        launch_buf, launch_new, launch;
    logic [21:0] l_addr, l_off;
    logic [7:0]  l_data;
    logic        l_prom;
    logic [3:0]  slot_q;
    logic        active;
    logic        done_cond;

    assign cap = ioctl_wr & downloading;

    // The buffered (older) entry always has priority over a fresh capture.
    always_comb begin
        launch_buf = (state == IDLE) && buf_valid;
        launch_new = (state == IDLE) && !buf_valid && cap;
        launch     = launch_buf || launch_new;
        l_addr     = launch_buf ? buf_addr : ioctl_addr;
        l_data     = launch_buf ? buf_data : ioctl_data;
        l_off      = l_addr - PROM_START;
        l_prom     = (l_addr >= PROM_START) && (l_off < PROM_SIZE);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch) state_nx = l_prom ? PROMWR : SDWR;
            SDWR:    if (sdram_ack) state_nx = IDLE;
            PROMWR:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        prog_we = (state == SDWR);
        prom_we = (state == PROMWR) ? (PROM_ONE << slot_q) : '0;
        busy    = (state != IDLE) || buf_valid;
    end

    // Write payload registers hold their last value between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= '0;
            slot_q    <= '0;
        end else if (launch) begin
            prog_data <= l_data;
            if (l_prom) begin
                prog_addr <= {14'd0, l_off[7:0]};
                slot_q    <= l_off[11:8];
            end else begin
                prog_addr <= {1'b0, l_addr[21:1]};
                prog_mask <= l_addr[0] ? 2'b01 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            overflow  <= 1'b0;
        end else if (launch_buf) begin
            buf_valid <= cap;
            if (cap) begin
                buf_addr <= ioctl_addr;
                buf_data <= ioctl_data;
            end
        end else if (cap && state != IDLE) begin
            if (!buf_valid) begin
                buf_valid <= 1'b1;
                buf_addr  <= ioctl_addr;
                buf_data  <= ioctl_data;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    // active remembers that a download happened since the last done pulse.
    assign done_cond = !downloading && (state == IDLE) && !buf_valid && active;

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= done_cond;
            if (downloading)    active <= 1'b1;
            else if (done_cond) active <= 1'b0;
        end
    end

endmodule
